// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response and shared-ALU signal bundle for alu_share_arbiter
// slave is the arbiter side; master is the client/ALU side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_sel;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [1:0]         alu_sel;
  logic [WIDTH-1:0]   alu_out;
  logic               busy;
  logic [7:0]         op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_sel, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_sel, busy, op_count
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter sharing one combinational ALU slice
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_arbiter #(
  parameter int WIDTH         = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   ifc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sel_q;
  logic             gnt_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [1:0]       rsp_valid_q;
  logic [7:0]       op_count_q;

  logic             gnt_d;
  logic [1:0]       ready_d;
  logic             accept;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [1:0]       sel_d;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_d = ~ifc.req_valid[0];
  end
`else
  logic last_q;

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    if (&ifc.req_valid) begin
      gnt_d = ~last_q;
    end else begin
      gnt_d = ~ifc.req_valid[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt_d;
    end
  end
`endif

  always_comb begin
    ready_d = 2'b00;
    if (state_q == IDLE) begin
      ready_d = ifc.req_valid & (gnt_d ? 2'b10 : 2'b01);
    end
  end

  assign accept = |ready_d;
  assign a_d    = gnt_d ? ifc.req_a[2*WIDTH-1:WIDTH] : ifc.req_a[WIDTH-1:0];
  assign b_d    = gnt_d ? ifc.req_b[2*WIDTH-1:WIDTH] : ifc.req_b[WIDTH-1:0];
  assign sel_d  = gnt_d ? ifc.req_sel[3:2] : ifc.req_sel[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 2'b00;
      gnt_q       <= 1'b0;
      cnt_q       <= 4'd0;
      res_q       <= '0;
      rsp_valid_q <= 2'b00;
      op_count_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= 4'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt_q == SETTLE_LAST) begin
            res_q       <= ifc.alu_out;
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          if (ifc.rsp_ready[gnt_q]) begin
            rsp_valid_q <= 2'b00;
            op_count_q  <= op_count_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ALU inputs come only from the latched operands so they never toggle outside ISSUE.
  assign ifc.alu_a     = a_q;
  assign ifc.alu_b     = b_q;
  assign ifc.alu_sel   = sel_q;
  assign ifc.req_ready = ready_d;
  assign ifc.rsp_valid = rsp_valid_q;
  assign ifc.rsp_data  = res_q;
  assign ifc.busy      = (state_q != IDLE);
  assign ifc.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
// dut_a runs with SETTLE_CYCLES=1, dut_b with SETTLE_CYCLES=3; honours ARB_FIXED_PRIO_EN.
module tb_alu_share_arbiter;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks   = 0;
  int   failures = 0;
  bit   ok;

  alu_share_arbiter_if #(.WIDTH(W)) ifa ();
  alu_share_arbiter_if #(.WIDTH(W)) ifb ();

  alu_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n),  .ifc(ifa));
  alu_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst2_n), .ifc(ifb));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb ifa.alu_out = alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_sel);
  always_comb ifb.alu_out = alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit use_b, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((use_b ? ifb.rsp_valid : ifa.rsp_valid) != 2'b00) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL rsp_timeout observed=none expected=rsp_valid");
    end
  endtask

  task automatic single_op_a(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] s, input logic [W-1:0] exp, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << r;
    ifa.req_a[r*W +: W]   = a;
    ifa.req_b[r*W +: W]   = b;
    ifa.req_sel[2*r +: 2] = s;
    ifa.req_valid         = oh;
    #1;
    check({tag, "_req_ready"}, ifa.req_ready, oh);
    tick();
    ifa.req_valid = 2'b00;
    ifa.rsp_ready = oh;
    wait_rsp(1'b0, ok);
    check({tag, "_rsp_valid"}, ifa.rsp_valid, oh);
    check({tag, "_rsp_data"}, ifa.rsp_data, exp);
    tick();
    ifa.rsp_ready = 2'b00;
  endtask

  logic [1:0] exp_order [4];

  initial begin
    ifa.req_valid = 0; ifa.req_a = 0; ifa.req_b = 0; ifa.req_sel = 0; ifa.rsp_ready = 0;
    ifb.req_valid = 0; ifb.req_a = 0; ifb.req_b = 0; ifb.req_sel = 0; ifb.rsp_ready = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    rst2_n = 1'b1;

    check("rst_req_ready", ifa.req_ready, 0);
    check("rst_rsp_valid", ifa.rsp_valid, 0);
    check("rst_rsp_data", ifa.rsp_data, 0);
    check("rst_alu_a", ifa.alu_a, 0);
    check("rst_alu_sel", ifa.alu_sel, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_op_count", ifa.op_count, 0);

    // Test 1: 3 + 4 on requester 0, one-cycle settle
    ifa.req_a[4:0] = 5'd3; ifa.req_b[4:0] = 5'd4; ifa.req_sel[1:0] = 2'b01;
    ifa.req_valid = 2'b01;
    #1;
    check("t1_req_ready", ifa.req_ready, 2'b01);
    tick();
    ifa.req_valid = 2'b00;
    ifa.rsp_ready = 2'b01;
    check("t1_issue_ready", ifa.req_ready, 2'b00);
    check("t1_issue_busy", ifa.busy, 1);
    check("t1_issue_rsp", ifa.rsp_valid, 2'b00);
    check("t1_alu_a", ifa.alu_a, 3);
    check("t1_alu_b", ifa.alu_b, 4);
    check("t1_alu_sel", ifa.alu_sel, 1);
    tick();
    check("t1_rsp_valid", ifa.rsp_valid, 2'b01);
    check("t1_rsp_data", ifa.rsp_data, 7);
    tick();
    ifa.rsp_ready = 2'b00;
    check("t1_rsp_clear", ifa.rsp_valid, 2'b00);
    check("t1_op_count", ifa.op_count, 1);
    check("t1_idle_busy", ifa.busy, 0);

    // Test 3: wrap-around add and xor on requester 1
    single_op_a(1, 5'd31, 5'd1, 2'b01, 5'd0, "t3_wrap");
    single_op_a(1, 5'd21, 5'd10, 2'b11, 5'd31, "t3_xor");
    check("t3_op_count", ifa.op_count, 3);

    // Test 2: both requesting from reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ifa.req_a = {5'd9, 5'd5};
    ifa.req_b = {5'd3, 5'd6};
    ifa.req_sel = {2'b10, 2'b00};
    ifa.req_valid = 2'b11;
    ifa.rsp_ready = 2'b11;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int k = 0; k < 4; k++) begin
      wait_rsp(1'b0, ok);
      check($sformatf("t2_grant%0d", k), ifa.rsp_valid, exp_order[k]);
      check($sformatf("t2_data%0d", k), ifa.rsp_data, (exp_order[k] == 2'b01) ? 4 : 11);
      tick();
    end
    ifa.req_valid = 2'b00;
    ifa.rsp_ready = 2'b00;
    check("t2_op_count", ifa.op_count, 4);

    // Test 4: response back-pressure, with competing requests and a stray rsp_ready[1]
    ifa.req_a[4:0] = 5'd12; ifa.req_b[4:0] = 5'd7; ifa.req_sel[1:0] = 2'b10;
    ifa.req_valid = 2'b01;
    tick();
    ifa.req_valid = 2'b11;
    ifa.rsp_ready = 2'b10;
    wait_rsp(1'b0, ok);
    for (int k = 0; k < 5; k++) begin
      check("t4_rsp_valid", ifa.rsp_valid, 2'b01);
      check("t4_rsp_data", ifa.rsp_data, 15);
      check("t4_req_ready", ifa.req_ready, 2'b00);
      check("t4_alu_a", ifa.alu_a, 12);
      check("t4_alu_b", ifa.alu_b, 7);
      check("t4_alu_sel", ifa.alu_sel, 2);
      check("t4_busy", ifa.busy, 1);
      check("t4_op_count", ifa.op_count, 4);
      tick();
    end
    ifa.req_valid = 2'b00;
    ifa.rsp_ready = 2'b01;
    tick();
    ifa.rsp_ready = 2'b00;
    check("t4_rsp_clear", ifa.rsp_valid, 2'b00);
    check("t4_op_count_done", ifa.op_count, 5);

    // Test 6: op_count wrap, one op every three cycles
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ifa.req_a[4:0] = 5'd1; ifa.req_b[4:0] = 5'd1; ifa.req_sel[1:0] = 2'b01;
    ifa.req_valid = 2'b01;
    ifa.rsp_ready = 2'b01;
    repeat (765) tick();
    check("t6_count255", ifa.op_count, 255);
    repeat (3) tick();
    check("t6_count256", ifa.op_count, 0);
    repeat (3) tick();
    check("t6_count257", ifa.op_count, 1);
    ifa.req_valid = 2'b00;
    ifa.rsp_ready = 2'b00;

    // Test 5: three-cycle settle latency, then reset mid-ISSUE
    ifb.req_a[4:0] = 5'd6; ifb.req_b[4:0] = 5'd9; ifb.req_sel[1:0] = 2'b01;
    ifb.req_valid = 2'b01;
    #1;
    check("t5_req_ready", ifb.req_ready, 2'b01);
    tick();
    ifb.req_valid = 2'b00;
    ifb.rsp_ready = 2'b01;
    check("t5_busy", ifb.busy, 1);
    check("t5_rsp_e0", ifb.rsp_valid, 2'b00);
    tick();
    check("t5_rsp_e1", ifb.rsp_valid, 2'b00);
    tick();
    check("t5_rsp_e2", ifb.rsp_valid, 2'b00);
    tick();
    check("t5_rsp_e3", ifb.rsp_valid, 2'b01);
    check("t5_rsp_data", ifb.rsp_data, 15);
    tick();
    ifb.rsp_ready = 2'b00;
    check("t5_op_count", ifb.op_count, 1);

    ifb.req_a[4:0] = 5'd1; ifb.req_b[4:0] = 5'd2; ifb.req_sel[1:0] = 2'b01;
    ifb.req_valid = 2'b01;
    tick();
    ifb.req_valid = 2'b00;
    ifb.rsp_ready = 2'b01;
    check("t5_busy2", ifb.busy, 1);
    check("t5_alu_a2", ifb.alu_a, 1);
    tick();
    #2;
    rst2_n = 1'b0;
    #1;
    check("t5_rst_busy", ifb.busy, 0);
    check("t5_rst_rsp_valid", ifb.rsp_valid, 0);
    check("t5_rst_rsp_data", ifb.rsp_data, 0);
    check("t5_rst_alu_a", ifb.alu_a, 0);
    check("t5_rst_alu_b", ifb.alu_b, 0);
    check("t5_rst_alu_sel", ifb.alu_sel, 0);
    check("t5_rst_op_count", ifb.op_count, 0);
    check("t5_rst_req_ready", ifb.req_ready, 0);
    tick();
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t5_no_rsp", ifb.rsp_valid, 2'b00);
      tick();
    end
    ifb.req_a = {5'd4, 5'd2};
    ifb.req_b = {5'd4, 5'd3};
    ifb.req_sel = {2'b01, 2'b00};
    ifb.req_valid = 2'b11;
    ifb.rsp_ready = 2'b11;
    #1;
    check("t5_tie_ready", ifb.req_ready, 2'b01);
    tick();
    ifb.req_valid = 2'b00;
    wait_rsp(1'b1, ok);
    check("t5_tie_grant", ifb.rsp_valid, 2'b01);
    check("t5_tie_data", ifb.rsp_data, 2);
    tick();
    ifb.rsp_ready = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
